// File: rtl/sa_matmul.sv
// Weight-stationary systolic matrix multiply: C = A * W with internal operand/result buffers.
// Contains the controller, the PE grid and the top-level buffer/skew logic.

module sa_ctrl #(
    parameter int NUM_ROWS = 4,
    parameter int NUM_COLS = 4,
    parameter int M        = 4,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    output logic             compute_en,
    output logic             w_shift,
    output logic [CNT_W-1:0] count,
    output logic             o_done
);
    typedef enum logic [1:0] {IDLE, LOAD_W, COMPUTE, DONE} state_t;

    state_t           curr_state, next_state;
    logic [CNT_W-1:0] count_r, count_n;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            curr_state <= IDLE;
            count_r    <= '0;
        end else begin
            curr_state <= next_state;
            count_r    <= count_n;
        end
    end

    always_comb begin
        next_state = curr_state;
        count_n    = count_r;
        compute_en = 1'b0;
        w_shift    = 1'b0;
        o_done     = 1'b0;
        case (curr_state)
            IDLE: begin
                count_n = '0;
                if (i_start) next_state = LOAD_W;
            end
            LOAD_W: begin
                w_shift = 1'b1;
                if (count_r == CNT_W'(NUM_ROWS - 1)) begin
                    next_state = COMPUTE;
                    count_n    = '0;
                end else begin
                    count_n = count_r + 1'b1;
                end
            end
            COMPUTE: begin
                compute_en = 1'b1;
                if (count_r == CNT_W'(M + NUM_ROWS + NUM_COLS - 2)) begin
                    next_state = DONE;
                    count_n    = '0;
                end else begin
                    count_n = count_r + 1'b1;
                end
            end
            DONE: begin
                o_done     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign count = count_r;
endmodule

module sa_array #(
    parameter int ADD_DATAWIDTH = 8,
    parameter int MUL_DATAWIDTH = 8,
    parameter int NUM_ROWS      = 4,
    parameter int NUM_COLS      = 4
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         compute_en,
    input  logic                                         w_shift,
    input  logic [NUM_ROWS-1:0][MUL_DATAWIDTH-1:0]       a_in,
    input  logic [NUM_COLS-1:0][MUL_DATAWIDTH-1:0]       w_in,
    output logic [NUM_COLS-1:0][ADD_DATAWIDTH-1:0]       psum_out
);
    // systolic_mode: 0 = LOAD, 1 = COMPUTE
    logic                       systolic_mode          [NUM_ROWS][NUM_COLS];
    logic [MUL_DATAWIDTH-1:0]   systolic_inputs        [NUM_ROWS][NUM_COLS];
    logic [MUL_DATAWIDTH-1:0]   systolic_input_weights [NUM_ROWS][NUM_COLS];
    logic [MUL_DATAWIDTH-1:0]   systolic_weights       [NUM_ROWS][NUM_COLS];
    logic [ADD_DATAWIDTH-1:0]   systolic_psums         [NUM_ROWS][NUM_COLS];
    logic [ADD_DATAWIDTH-1:0]   systolic_outputs       [NUM_ROWS][NUM_COLS];
    logic [MUL_DATAWIDTH-1:0]   act_r                  [NUM_ROWS][NUM_COLS];
    logic [2*MUL_DATAWIDTH-1:0] prod                   [NUM_ROWS][NUM_COLS];

    always_comb begin
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            systolic_inputs[r][0] = a_in[r];
            for (int unsigned c = 1; c < NUM_COLS; c++)
                systolic_inputs[r][c] = act_r[r][c-1];
        end
        for (int unsigned c = 0; c < NUM_COLS; c++) begin
            systolic_input_weights[0][c] = w_in[c];
            systolic_psums[0][c]         = '0;
            for (int unsigned r = 1; r < NUM_ROWS; r++) begin
                systolic_input_weights[r][c] = systolic_weights[r-1][c];
                systolic_psums[r][c]         = systolic_outputs[r-1][c];
            end
        end
        for (int unsigned r = 0; r < NUM_ROWS; r++)
            for (int unsigned c = 0; c < NUM_COLS; c++) begin
                systolic_mode[r][c] = compute_en;
                prod[r][c]          = systolic_inputs[r][c] * systolic_weights[r][c];
            end
    end

    // Act/psum pipelines are flushed while loading so a new run never sees stale partial sums.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int unsigned r = 0; r < NUM_ROWS; r++)
                for (int unsigned c = 0; c < NUM_COLS; c++) begin
                    act_r[r][c]            <= '0;
                    systolic_weights[r][c] <= '0;
                    systolic_outputs[r][c] <= '0;
                end
        end else begin
            for (int unsigned r = 0; r < NUM_ROWS; r++)
                for (int unsigned c = 0; c < NUM_COLS; c++) begin
                    if (systolic_mode[r][c]) begin
                        act_r[r][c]            <= systolic_inputs[r][c];
                        systolic_outputs[r][c] <= systolic_psums[r][c] + ADD_DATAWIDTH'(prod[r][c]);
                    end else begin
                        act_r[r][c]            <= '0;
                        systolic_outputs[r][c] <= '0;
                        if (w_shift)
                            systolic_weights[r][c] <= systolic_input_weights[r][c];
                    end
                end
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < NUM_COLS; c++)
            psum_out[c] = systolic_outputs[NUM_ROWS-1][c];
    end
endmodule

module sa_matmul #(
    parameter int ADD_DATAWIDTH = 8,
    parameter int MUL_DATAWIDTH = 8,
    parameter int NUM_ROWS      = 4,
    parameter int NUM_COLS      = 4,
    parameter int M             = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    output logic o_done
);
    localparam int CNT_W = $clog2(M + NUM_ROWS + NUM_COLS);

    logic [MUL_DATAWIDTH-1:0] A [M][NUM_ROWS];
    logic [MUL_DATAWIDTH-1:0] W [NUM_ROWS][NUM_COLS];
    logic [ADD_DATAWIDTH-1:0] C [M][NUM_COLS];

    logic                                   compute_en, w_shift;
    logic [CNT_W-1:0]                       count;
    logic [NUM_ROWS-1:0][MUL_DATAWIDTH-1:0] a_in;
    logic [NUM_COLS-1:0][MUL_DATAWIDTH-1:0] w_in;
    logic [NUM_COLS-1:0][ADD_DATAWIDTH-1:0] psum_out;

    sa_ctrl #(
        .NUM_ROWS(NUM_ROWS),
        .NUM_COLS(NUM_COLS),
        .M       (M),
        .CNT_W   (CNT_W)
    ) sys_array_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (i_start),
        .compute_en(compute_en),
        .w_shift   (w_shift),
        .count     (count),
        .o_done    (o_done)
    );

    sa_array #(
        .ADD_DATAWIDTH(ADD_DATAWIDTH),
        .MUL_DATAWIDTH(MUL_DATAWIDTH),
        .NUM_ROWS     (NUM_ROWS),
        .NUM_COLS     (NUM_COLS)
    ) sys_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .compute_en(compute_en),
        .w_shift   (w_shift),
        .a_in      (a_in),
        .w_in      (w_in),
        .psum_out  (psum_out)
    );

    // Operand buffers only change on reset; otherwise they are written by backdoor while idle.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int unsigned m = 0; m < M; m++)
                for (int unsigned k = 0; k < NUM_ROWS; k++)
                    A[m][k] <= MUL_DATAWIDTH'(m + k);
            for (int unsigned k = 0; k < NUM_ROWS; k++)
                for (int unsigned n = 0; n < NUM_COLS; n++)
                    W[k][n] <= MUL_DATAWIDTH'(k * NUM_COLS + n + 1);
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int unsigned m = 0; m < M; m++)
                for (int unsigned n = 0; n < NUM_COLS; n++)
                    C[m][n] <= '0;
        end else if (compute_en) begin
            for (int unsigned m = 0; m < M; m++)
                for (int unsigned n = 0; n < NUM_COLS; n++)
                    if (count == CNT_W'(m + n + NUM_ROWS))
                        C[m][n] <= psum_out[n];
        end
    end

    // Skew: row k sees A[t-k][k] at compute count t; weights enter bottom row first.
    always_comb begin
        for (int unsigned k = 0; k < NUM_ROWS; k++) begin
            a_in[k] = '0;
            for (int unsigned m = 0; m < M; m++)
                if (compute_en && count == CNT_W'(m + k))
                    a_in[k] = A[m][k];
        end
        for (int unsigned n = 0; n < NUM_COLS; n++) begin
            w_in[n] = '0;
            for (int unsigned r = 0; r < NUM_ROWS; r++)
                if (w_shift && count == CNT_W'(NUM_ROWS - 1 - r))
                    w_in[n] = W[r][n];
        end
    end
endmodule

// File: tb/tb_sa_matmul.sv
// Directed self-checking bench for sa_matmul: reset, idle, preload, full run, overflow, abort.

module tb_sa_matmul;
    localparam int ST_IDLE = 0, ST_LOAD_W = 1, ST_COMPUTE = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic i_start;
    logic o_done;

    int total = 0;
    int bad   = 0;

    sa_matmul #(
        .ADD_DATAWIDTH(8),
        .MUL_DATAWIDTH(8),
        .NUM_ROWS     (4),
        .NUM_COLS     (4),
        .M            (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_start(i_start),
        .o_done (o_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_c_default(input string tag);
        int unsigned e;
        for (int m = 0; m < 4; m++)
            for (int n = 0; n < 4; n++) begin
                e = 0;
                for (int k = 0; k < 4; k++) e += (m + k) * (4 * k + n + 1);
                check($sformatf("%s_C%0d%0d", tag, m, n), 32'(dut.C[m][n]), e % 256);
            end
        check({tag, "_C00"}, 32'(dut.C[0][0]), 62);
        check({tag, "_C10"}, 32'(dut.C[1][0]), 90);
        check({tag, "_C33"}, 32'(dut.C[3][3]), 200);
    endtask

    task automatic check_c_const(input string tag, input int unsigned v);
        for (int m = 0; m < 4; m++)
            for (int n = 0; n < 4; n++)
                check($sformatf("%s_C%0d%0d", tag, m, n), 32'(dut.C[m][n]), v);
    endtask

    // lat counts negedges after the posedge that sampled i_start; 100 means timeout.
    task automatic run_wait(output int lat);
        @(negedge clk) i_start = 1'b1;
        @(negedge clk) i_start = 1'b0;
        lat = 1;
        while (!o_done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int pulses;
        int wrong_state;
        int guard;

        rst_n   = 1'b1;
        i_start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_state", 32'(dut.sys_array_ctrl.curr_state), ST_IDLE);
        check("rst_count", 32'(dut.sys_array_ctrl.count_r), 0);
        check("rst_done", 32'(o_done), 0);
        check_c_const("rst", 0);
        check("rst_W33", 32'(dut.W[3][3]), 16);
        check("rst_A33", 32'(dut.A[3][3]), 6);
        check("rst_pe_w", 32'(dut.sys_array.systolic_weights[2][1]), 0);

        pulses = 0;
        wrong_state = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_done) pulses++;
            if (32'(dut.sys_array_ctrl.curr_state) != ST_IDLE) wrong_state++;
        end
        check("idle_done_pulses", 32'(pulses), 0);
        check("idle_state_bad", 32'(wrong_state), 0);

        @(negedge clk) i_start = 1'b1;
        @(negedge clk) i_start = 1'b0;
        lat = 1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("load_state%0d", i), 32'(dut.sys_array_ctrl.curr_state), ST_LOAD_W);
            check($sformatf("load_count%0d", i), 32'(dut.sys_array_ctrl.count_r), 32'(i));
            @(negedge clk);
            lat++;
        end
        check("cmp_entry_state", 32'(dut.sys_array_ctrl.curr_state), ST_COMPUTE);
        check("cmp_entry_count", 32'(dut.sys_array_ctrl.count_r), 0);
        for (int k = 0; k < 4; k++)
            for (int n = 0; n < 4; n++)
                check($sformatf("pe_w%0d%0d", k, n), 32'(dut.sys_array.systolic_weights[k][n]),
                      32'(4 * k + n + 1));
        pulses = 0;
        while (!o_done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("run1_latency", 32'(lat), 16);
        @(negedge clk);
        check("run1_done_width", 32'(o_done), 0);
        check("run1_back_idle", 32'(dut.sys_array_ctrl.curr_state), ST_IDLE);
        check_c_default("run1");

        for (int m = 0; m < 4; m++)
            for (int k = 0; k < 4; k++) dut.A[m][k] = 8'd255;
        for (int k = 0; k < 4; k++)
            for (int n = 0; n < 4; n++) dut.W[k][n] = 8'd255;
        run_wait(lat);
        check("ovf_latency", 32'(lat), 16);
        @(negedge clk);
        check_c_const("ovf", 4);

        rst_n = 1'b1;
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) i_start = 1'b1;
        @(negedge clk) i_start = 1'b0;
        guard = 0;
        while (!(32'(dut.sys_array_ctrl.curr_state) == ST_COMPUTE &&
                 dut.sys_array_ctrl.count_r == 5) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("abort_reach_cnt5", 32'(guard < 50), 1);
        check("abort_C00_before", 32'(dut.C[0][0]), 62);
        rst_n = 1'b1;
        #1;
        check("abort_state", 32'(dut.sys_array_ctrl.curr_state), ST_IDLE);
        check("abort_count", 32'(dut.sys_array_ctrl.count_r), 0);
        check("abort_done", 32'(o_done), 0);
        check_c_const("abort", 0);
        check("abort_A33", 32'(dut.A[3][3]), 6);
        @(negedge clk) rst_n = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_done) pulses++;
        end
        check("abort_no_done", 32'(pulses), 0);

        run_wait(lat);
        check("run2_latency", 32'(lat), 16);
        @(negedge clk);
        check_c_default("run2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
